// File: rtl/npcg_toggle_scc_pm_arbiter_if.sv
// Bundles the requester-side and PM-side buses of the SCC/PM arbiter.
// Pure wiring, no latency.
// No backpressure of its own; the arbiter grants and holds the bus until release.
interface npcg_toggle_scc_pm_arbiter_if #(
   parameter int N = 4
);
   // Requester side
   logic [N-1:0]    iReqValid;
   logic [N-1:0]    iReqLastStep;
   logic [8*N-1:0]  iReqPCommand;
   logic [3*N-1:0]  iReqPCommandOption;
   logic [16*N-1:0] iReqNumOfData;
   logic [N-1:0]    oGrant;
   logic [8*N-1:0]  oReqPM_Ready;
   logic [8*N-1:0]  oReqPM_LastStep;
   // Primitive-manager side
   logic [7:0]      iPM_Ready;
   logic [7:0]      iPM_LastStep;
   logic [7:0]      oPM_PCommand;
   logic [2:0]      oPM_PCommandOption;
   logic [15:0]     oPM_NumOfData;
   logic            oBusy;

   // Arbiter view
   modport slave (
      input  iReqValid, iReqLastStep, iReqPCommand, iReqPCommandOption, iReqNumOfData,
      input  iPM_Ready, iPM_LastStep,
      output oGrant, oReqPM_Ready, oReqPM_LastStep,
      output oPM_PCommand, oPM_PCommandOption, oPM_NumOfData, oBusy
   );

   // Requesters/PM view
   modport master (
      output iReqValid, iReqLastStep, iReqPCommand, iReqPCommandOption, iReqNumOfData,
      output iPM_Ready, iPM_LastStep,
      input  oGrant, oReqPM_Ready, oReqPM_LastStep,
      input  oPM_PCommand, oPM_PCommandOption, oPM_NumOfData, oBusy
   );
endinterface

// File: rtl/npcg_toggle_scc_pm_arbiter.sv
// Round-robin arbiter sharing one PM command port among SCC sequencers.
// Grant appears one cycle after request; a one-cycle Release separates grants.
// Grant held until the owner's LastStep or withdrawal; others wait, no preemption.
module npcg_toggle_scc_pm_arbiter #(
   parameter int NumberOfRequesters = 4
) (
   input  logic                          iSystemClock,
   input  logic                          iReset,
   npcg_toggle_scc_pm_arbiter_if.slave   bus
);

   localparam int N     = NumberOfRequesters;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRANTED,
      ST_RELEASE
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
   logic [IDX_W-1:0]   last_idx_q, last_idx_d;

   // Next-state, round-robin selection and output muxing
   always_comb begin
      int               cand;
      logic [IDX_W-1:0] cidx;
      logic             found;
      logic             own_valid;
      logic             own_last;

      state_d     = state_q;
      grant_idx_d = grant_idx_q;
      last_idx_d  = last_idx_q;
      cand        = 0;
      cidx        = '0;
      found       = 1'b0;
      own_valid   = 1'b0;
      own_last    = 1'b0;

      bus.oGrant             = '0;
      bus.oReqPM_Ready       = '0;
      bus.oReqPM_LastStep    = '0;
      bus.oPM_PCommand       = 8'h00;
      bus.oPM_PCommandOption = 3'b000;
      bus.oPM_NumOfData      = 16'd0;
      bus.oBusy              = (state_q != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            // Search starts just past the last owner so everyone gets a turn.
            for (int i = 1; i <= N; i++) begin
               cand = int'(last_idx_q) + i;
               if (cand >= N) cand = cand - N;
               cidx = IDX_W'(cand);
               if (!found && bus.iReqValid[cidx]) begin
                  found       = 1'b1;
                  grant_idx_d = cidx;
               end
            end
            if (found) state_d = ST_GRANTED;
         end

         ST_GRANTED: begin
            for (int k = 0; k < N; k++) begin
               if (grant_idx_q == IDX_W'(k)) begin
                  bus.oGrant[k]                 = 1'b1;
                  bus.oPM_PCommand              = bus.iReqPCommand[8*k +: 8];
                  bus.oPM_PCommandOption        = bus.iReqPCommandOption[3*k +: 3];
                  bus.oPM_NumOfData             = bus.iReqNumOfData[16*k +: 16];
                  bus.oReqPM_Ready[8*k +: 8]    = bus.iPM_Ready;
                  bus.oReqPM_LastStep[8*k +: 8] = bus.iPM_LastStep;
                  own_valid                     = bus.iReqValid[k];
                  own_last                      = bus.iReqLastStep[k];
               end
            end
            // LastStep and withdrawal together are a single release.
            if (own_last || !own_valid) state_d = ST_RELEASE;
         end

         ST_RELEASE: begin
            // Outputs stay at zero so the PM sees the command drop.
            last_idx_d = grant_idx_q;
            state_d    = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State and pointer registers with synchronous active-low reset
   always_ff @(posedge iSystemClock) begin
      if (!iReset) begin
         state_q     <= ST_IDLE;
         grant_idx_q <= '0;
         last_idx_q  <= IDX_W'(N - 1);
      end else begin
         state_q     <= state_d;
         grant_idx_q <= grant_idx_d;
         last_idx_q  <= last_idx_d;
      end
   end

endmodule

// File: tb/tb_npcg_toggle_scc_pm_arbiter.sv
// Directed bench for the SCC/PM round-robin arbiter with an expected-output queue.
// Inputs change 1 ns after the rising edge; outputs are compared 1 ns later.
// Each comparison step pops one expected snapshot of all outputs.
module tb_npcg_toggle_scc_pm_arbiter;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   npcg_toggle_scc_pm_arbiter_if #(.N(N)) bus();

   npcg_toggle_scc_pm_arbiter #(.NumberOfRequesters(N)) dut (
      .iSystemClock (clk),
      .iReset       (rst_n),
      .bus          (bus)
   );

   typedef struct {
      string       tag;
      logic [3:0]  grant;
      logic [7:0]  cmd;
      logic [2:0]  opt;
      logic [15:0] nod;
      logic        busy;
      logic [31:0] rdy;
      logic [31:0] ls;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int k, input logic [7:0] cmd, input logic [2:0] opt,
                          input logic [15:0] nod);
      bus.iReqPCommand[8*k +: 8]        = cmd;
      bus.iReqPCommandOption[3*k +: 3]  = opt;
      bus.iReqNumOfData[16*k +: 16]     = nod;
   endtask

   task automatic push_exp(input string tag, input logic [3:0] grant, input logic [7:0] cmd,
                           input logic [2:0] opt, input logic [15:0] nod, input logic busy,
                           input logic [31:0] rdy, input logic [31:0] ls);
      exp_t e;
      e.tag = tag; e.grant = grant; e.cmd = cmd; e.opt = opt; e.nod = nod;
      e.busy = busy; e.rdy = rdy; e.ls = ls;
      sb.push_back(e);
   endtask

   task automatic push_idle(input string tag, input logic busy);
      push_exp(tag, 4'b0000, 8'h00, 3'b000, 16'd0, busy, 32'h0, 32'h0);
   endtask

   // Expected owner-k outputs in the round-robin/withdrawal phase
   task automatic push_grant(input string tag, input int k);
      push_exp(tag, 4'(1 << k), 8'(8'h10 + k), 3'(k), 16'(1000 + k), 1'b1,
               32'h0000_0001 << (8*k), 32'h0000_0080 << (8*k));
   endtask

   task automatic cmp(input string tag, input string field, input logic [31:0] obs,
                      input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s.%s: observed %0h expected %0h", tag, field, obs, expv);
      end
   endtask

   task automatic check_out();
      exp_t e;
      #1;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard: no expected entry queued");
      end else begin
         e = sb.pop_front();
         cmp(e.tag, "grant", 32'(bus.oGrant), 32'(e.grant));
         cmp(e.tag, "pcmd",  32'(bus.oPM_PCommand), 32'(e.cmd));
         cmp(e.tag, "popt",  32'(bus.oPM_PCommandOption), 32'(e.opt));
         cmp(e.tag, "nod",   32'(bus.oPM_NumOfData), 32'(e.nod));
         cmp(e.tag, "busy",  32'(bus.oBusy), 32'(e.busy));
         cmp(e.tag, "rdy",   bus.oReqPM_Ready, e.rdy);
         cmp(e.tag, "ls",    bus.oReqPM_LastStep, e.ls);
      end
   endtask

   int order[5] = '{0, 1, 2, 3, 0};

   initial begin
      bus.iReqValid          = '0;
      bus.iReqLastStep       = '0;
      bus.iReqPCommand       = '0;
      bus.iReqPCommandOption = '0;
      bus.iReqNumOfData      = '0;
      bus.iPM_Ready          = 8'h01;
      bus.iPM_LastStep       = 8'h80;

      // Reset, then idle with no requests
      tick(); tick();
      push_idle("reset", 1'b0); check_out();
      rst_n = 1'b1;
      tick();
      push_idle("idle_noreq", 1'b0); check_out();

      // Single request from requester 2
      set_req(2, 8'h01, 3'd2, 16'd11000);
      bus.iReqValid = 4'b0100;
      push_idle("single_pre", 1'b0); check_out();
      tick();
      push_exp("single_grant", 4'b0100, 8'h01, 3'd2, 16'd11000, 1'b1, 32'h0001_0000, 32'h0080_0000);
      check_out();
      bus.iReqLastStep = 4'b0100;
      bus.iReqValid    = 4'b0000;
      push_exp("single_hold", 4'b0100, 8'h01, 3'd2, 16'd11000, 1'b1, 32'h0001_0000, 32'h0080_0000);
      check_out();
      tick();
      bus.iReqLastStep = 4'b0000;
      push_idle("single_release", 1'b1); check_out();
      tick();
      push_idle("single_idle", 1'b0); check_out();

      // Fresh reset so requester 0 has top priority again
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      push_idle("reset2", 1'b0); check_out();

      // Round robin with everyone requesting
      for (int k = 0; k < N; k++) set_req(k, 8'(8'h10 + k), 3'(k), 16'(1000 + k));
      bus.iReqValid = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick();
         push_grant($sformatf("rr%0d_grant", i), order[i]); check_out();
         bus.iReqLastStep = 4'(1 << order[i]);
         tick();
         bus.iReqLastStep = 4'b0000;
         push_idle($sformatf("rr%0d_release", i), 1'b1); check_out();
         tick();
         push_idle($sformatf("rr%0d_idle", i), 1'b0); check_out();
      end

      // Withdrawal: requester 1 drops its request without LastStep
      tick();
      push_grant("wd_grant1", 1); check_out();
      bus.iReqValid = 4'b1101;
      tick();
      push_idle("wd_release", 1'b1); check_out();
      tick();
      push_idle("wd_idle", 1'b0); check_out();
      tick();
      push_grant("wd_grant2", 2); check_out();

      // Move the grant to requester 1 for the isolation check
      bus.iReqLastStep = 4'b0100;
      bus.iReqValid    = 4'b0010;
      tick();
      bus.iReqLastStep = 4'b0000;
      push_idle("iso_release", 1'b1); check_out();
      tick();
      push_idle("iso_idle", 1'b0); check_out();
      tick();
      push_grant("iso_grant1", 1); check_out();

      // Requester 3 shouts on its own slice; requester 1 keeps the PM
      bus.iReqValid    = 4'b1010;
      set_req(3, 8'hFF, 3'd7, 16'hFFFF);
      bus.iReqLastStep = 4'b1000;
      push_grant("iso_same", 1); check_out();
      tick();
      push_grant("iso_next", 1); check_out();
      bus.iReqLastStep = 4'b0000;

      // Reset while granted, then full contention after release
      rst_n = 1'b0;
      tick();
      push_idle("rst_mid", 1'b0); check_out();
      rst_n = 1'b1;
      bus.iReqValid = 4'b1111;
      set_req(3, 8'h13, 3'd3, 16'd1003);
      tick();
      push_grant("post_rst_grant0", 0); check_out();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/npcg_toggle_scc_pm_arbiter.md
Name: npcg_toggle_scc_pm_arbiter

Overview:
Shares the single primitive-manager (PM) command interface among NumberOfRequesters SCC command-sequencer sub-modules, such as the POE, set-feature and reset sequencers.
It grants the PM to one requester at a time in round-robin order and holds the grant until that requester reports its sequence done.
While a requester holds the grant, the block muxes that requester's PCommand, PCommandOption and NumOfData onto the PM.
It routes PM Ready/LastStep back only to the granted requester, so the SCC modules never contend on the PM bus.

Parameters:
NumberOfRequesters, 4, number of SCC requesters sharing the PM (2..8).

Ports:
iSystemClock  input  1  system clock; all logic on the rising edge.
iReset  input  1  synchronous, active-low reset.
iReqValid  input  N  per-requester request; held high for the whole sequence.
iReqLastStep  input  N  per-requester sequence-done pulse (the requester's oLastStep).
iReqPCommand  input  8*N  per-requester PCommand; requester k occupies bits [8k+7:8k].
iReqPCommandOption  input  3*N  per-requester PCommandOption, packed the same way.
iReqNumOfData  input  16*N  per-requester NumOfData, packed the same way.
oGrant  output  N  one-hot grant; all zero when no requester is granted.
oReqPM_Ready  output  8*N  iPM_Ready routed to the granted requester's slice; other slices zero.
oReqPM_LastStep  output  8*N  iPM_LastStep routed the same way.
iPM_Ready  input  8  PM ready.
iPM_LastStep  input  8  PM last step.
oPM_PCommand  output  8  muxed PCommand to the PM.
oPM_PCommandOption  output  3  muxed PCommandOption.
oPM_NumOfData  output  16  muxed NumOfData.
oBusy  output  1  high in any state other than Idle.

Behaviour:
- N = NumberOfRequesters.
- State register:
  - States: Idle, Granted, Release.
  - Registers: rGrantIdx (index of the granted requester) and rLastIdx (round-robin pointer).
- Reset (iReset==0 at a clock edge):
  - State goes to Idle; oGrant = 0; rLastIdx = N-1, so requester 0 has top priority first.
  - All PM outputs are 0; all oReqPM_* outputs are 0; oBusy = 0.
- Idle:
  - If any iReqValid bit is high, select the first set bit searching from rLastIdx+1 upward, wrapping mod N.
  - Register that index into rGrantIdx and go to Granted.
  - Latency: iReqValid rising at edge t gives oGrant high after edge t+1 (one cycle).
- Granted:
  - oGrant = one-hot(rGrantIdx).
  - oPM_PCommand, oPM_PCommandOption and oPM_NumOfData equal the granted requester's slices, combinationally.
  - oReqPM_Ready and oReqPM_LastStep slice rGrantIdx equal iPM_Ready and iPM_LastStep; all other slices are 0.
  - Exit to Release when iReqLastStep[rGrantIdx]==1 or iReqValid[rGrantIdx]==0 (withdrawal).
  - Requests arriving from other requesters are ignored until Release completes; there is no preemption.
- Release (exactly one cycle):
  - oGrant = 0; all PM outputs forced to 0 so the PM sees the command drop; all oReqPM_* outputs are 0.
  - rLastIdx <= rGrantIdx; next state Idle.
- Back-to-back: a requester granted then released needs 3 cycles before it can be re-granted (Granted exit, Release, Idle, then re-grant).
- Fairness:
  - With all N requesting continuously, grants cycle 0,1,...,N-1,0.
  - No requester waits more than N-1 other grants.
- Outputs not granted: in Idle and Release, oPM_PCommand = 8'h00, oPM_PCommandOption = 3'b000, oPM_NumOfData = 16'd0.
- Simultaneous iReqLastStep and iReqValid fall on the granted requester: treated as one release event.
- iReqLastStep from a non-granted requester: ignored.
- Reset mid-grant: the next state is Idle and all outputs are zero on the following cycle; any in-flight PM command is dropped.

Test Plan:
- Reset then idle: iReset=0 for 2 cycles, no requests -> oGrant=0, oPM_PCommand=0, oBusy=0.
- Single request:
  - Stimulus: iReqValid=4'b0100; requester 2 drives PCommand 8'h01, NumOfData 16'd11000.
  - Required: oGrant=4'b0100 one cycle later; oPM_PCommand=8'h01, oPM_NumOfData=11000; iPM_Ready=8'h01 appears only on oReqPM_Ready[23:16].
  - Then: iReqLastStep[2] pulse -> one Release cycle with all outputs 0, then Idle.
- Round-robin: iReqValid=4'b1111 held, each grant released by LastStep -> grant order 0,1,2,3,0.
- Withdrawal: the granted requester drops iReqValid without LastStep -> Release next cycle; the next pending requester is granted two cycles later.
- Isolation:
  - Stimulus: while requester 1 is granted, requester 3 drives PCommand 8'hFF and pulses iReqLastStep[3].
  - Required: PM outputs remain requester 1's values; the grant is unchanged.
- Reset mid-operation: iReset=0 while Granted -> oGrant=0 and PM outputs 0 after that edge; after reset releases, requester 0 wins a full contention.
